// File: rtl/run_ctrl.sv
// Run sequencer and scorer for one grid test: holds the core in reset,
// releases it for a run, scores every output-lane transfer, stops on done/idle.
module run_ctrl #(
  parameter int LANES       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        lane_len   [0:LANES-1],
  input  logic              lane_write [0:LANES-1],
  input  logic              lane_read  [0:LANES-1],
  input  logic signed [10:0] lane_out  [0:LANES-1],
  input  logic signed [10:0] exp_data  [0:LANES-1],
  output logic [5:0]        exp_idx    [0:LANES-1],
  output logic              core_rst,
  output logic [7:0]        correct,
  output logic [7:0]        count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int NW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [5:0]      r_len [0:LANES-1];
  logic [5:0]      r_idx [0:LANES-1];
  logic [7:0]      r_count;
  logic [7:0]      r_correct;
  logic [HW-1:0]   r_hold;
  logic [WW-1:0]   r_wd;
  logic            r_ovr;
  logic            r_timeout;

  logic            w_xfer   [0:LANES-1];
  logic            w_inr    [0:LANES-1];
  logic [5:0]      w_idx_nx [0:LANES-1];
  logic [NW-1:0]   w_nin;
  logic [NW-1:0]   w_nok;
  logic            w_any;
  logic            w_ovr;
  logic            w_cmpl;
  logic [WW-1:0]   w_wd_nx;
  logic            w_tmo;

  function automatic logic [7:0] sat_add(
    input logic [7:0]    a,
    input logic [NW-1:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Per-lane scoring of this cycle's transfers; completion looks at next idx
  always_comb begin
    w_nin  = '0;
    w_nok  = '0;
    w_any  = 1'b0;
    w_ovr  = 1'b0;
    w_cmpl = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      w_xfer[i]   = lane_write[i] & lane_read[i];
      w_inr[i]    = w_xfer[i] && (r_idx[i] < r_len[i]);
      w_idx_nx[i] = r_idx[i] + (w_inr[i] ? 6'd1 : 6'd0);
      if (w_inr[i]) w_nin = w_nin + NW'(1);
      if (w_inr[i] && lane_out[i] == exp_data[i]) w_nok = w_nok + NW'(1);
      if (w_xfer[i]) w_any = 1'b1;
      if (w_xfer[i] && !w_inr[i]) w_ovr = 1'b1;
      if (w_idx_nx[i] != r_len[i]) w_cmpl = 1'b0;
    end
    w_wd_nx = w_any ? '0 : r_wd + WW'(1);
    w_tmo   = (w_wd_nx == WW'(TIMEOUT));
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nx = S_HOLD;
      S_HOLD: if (r_hold == '0) w_state_nx = S_RUN;
      S_RUN:  if (w_cmpl || w_tmo) w_state_nx = S_DONE;
      S_DONE: if (start) w_state_nx = S_HOLD;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_correct <= '0;
      r_hold    <= '0;
      r_wd      <= '0;
      r_ovr     <= 1'b0;
      r_timeout <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_len[i] <= '0;
        r_idx[i] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_count   <= '0;
            r_correct <= '0;
            r_hold    <= HW'(HOLD_CYCLES - 1);
            r_wd      <= '0;
            r_ovr     <= 1'b0;
            r_timeout <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
              r_len[i] <= lane_len[i];
              r_idx[i] <= '0;
            end
          end
        end
        S_HOLD: begin
          if (r_hold != '0) r_hold <= r_hold - HW'(1);
        end
        S_RUN: begin
          r_count   <= sat_add(r_count, w_nin);
          r_correct <= sat_add(r_correct, w_nok);
          r_wd      <= w_wd_nx;
          if (w_ovr) r_ovr <= 1'b1;
          // completion in the same cycle as the watchdog expiry wins
          if (!w_cmpl && w_tmo) r_timeout <= 1'b1;
          for (int i = 0; i < LANES; i++) r_idx[i] <= w_idx_nx[i];
        end
        default: ;
      endcase
    end
  end

  assign exp_idx  = r_idx;
  assign core_rst = (r_state != S_RUN);
  assign busy     = (r_state == S_HOLD) || (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign pass     = done && !r_timeout && !r_ovr && (r_correct == r_count);
  assign timeout  = r_timeout;
  assign count    = r_count;
  assign correct  = r_correct;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: each run pushes its expected final score,
// a monitor pops and compares whenever done rises.
module tb_run_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [5:0]        lane_len   [0:3];
  logic              lane_write [0:3];
  logic              lane_read  [0:3];
  logic signed [10:0] lane_out  [0:3];
  logic signed [10:0] exp_data  [0:3];
  logic [5:0]        exp_idx    [0:3];
  logic              core_rst;
  logic [7:0]        correct;
  logic [7:0]        count;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;

  logic signed [10:0] mem [0:3][0:63];

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] cor;
    logic       ps;
    logic       to;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic done_q = 1'b0;

  run_ctrl #(.LANES(4), .HOLD_CYCLES(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start(start),
    .lane_len(lane_len), .lane_write(lane_write),
    .lane_read(lane_read), .lane_out(lane_out),
    .exp_data(exp_data), .exp_idx(exp_idx),
    .core_rst(core_rst), .correct(correct), .count(count),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 4; i++) exp_data[i] = mem[i][exp_idx[i]];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got done=1 expected none");
      end else begin
        e = q.pop_front();
        check("sb_count", count, e.cnt);
        check("sb_correct", correct, e.cor);
        check("sb_pass", pass, e.ps);
        check("sb_timeout", timeout, e.to);
      end
    end
    done_q = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    for (int i = 0; i < 4; i++) begin
      lane_write[i] = 1'b0;
      lane_read[i]  = 1'b0;
      lane_out[i]   = '0;
    end
  endtask

  task automatic xfer(input logic [3:0] m,
                      input logic signed [10:0] v0, input logic signed [10:0] v1);
    for (int i = 0; i < 4; i++) begin
      lane_write[i] = m[i];
      lane_read[i]  = m[i];
      lane_out[i]   = '0;
    end
    lane_out[0] = v0;
    lane_out[1] = v1;
    tick();
  endtask

  task automatic start_run(input logic [5:0] l0, input logic [5:0] l1);
    lane_len[0] = l0;
    lane_len[1] = l1;
    lane_len[2] = 6'd0;
    lane_len[3] = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (core_rst && n < 20) begin
      tick();
      n++;
    end
    if (core_rst) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_run: got core_rst=1 expected 0 within 20 cycles");
    end
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      tick();
      n++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: got done=0 expected 1 within %0d cycles", lim);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 64; j++) mem[i][j] = '0;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) lane_len[i] = '0;
    quiet();
    repeat (3) tick();
    check("rst_core_rst", core_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_count", count, 0);
    check("rst_correct", correct, 0);
    rst = 1'b0;
    tick();

    // single lane, three matching values, hold timing
    mem[0][0] = 11'sd5;
    mem[0][1] = -11'sd7;
    mem[0][2] = 11'sd999;
    q.push_back('{8'd3, 8'd3, 1'b1, 1'b0});
    start_run(6'd3, 6'd0);
    for (int k = 0; k < 4; k++) begin
      check("hold_core_rst", core_rst, 1);
      check("hold_busy", busy, 1);
      tick();
    end
    check("run_core_rst", core_rst, 0);
    xfer(4'b0001, 11'sd5, 0);
    xfer(4'b0001, -11'sd7, 0);
    xfer(4'b0001, 11'sd999, 0);
    quiet();
    check("t1_done_next", done, 1);
    check("t1_busy_fall", busy, 0);

    // two lanes in parallel, one mismatch, plus a stalled offer
    mem[0][0] = 11'sd1;
    mem[0][1] = 11'sd2;
    mem[1][0] = 11'sd999;
    mem[1][1] = 11'sd4;
    q.push_back('{8'd4, 8'd3, 1'b0, 1'b0});
    start_run(6'd2, 6'd2);
    wait_run();
    lane_write[0] = 1'b1;
    lane_out[0]   = 11'sd1;
    tick();
    check("t2_stall_idx", exp_idx[0], 0);
    xfer(4'b0011, 11'sd1, -11'sd999);
    check("t2_mid_count", count, 2);
    check("t2_mid_correct", correct, 1);
    xfer(4'b0011, 11'sd2, 11'sd4);
    quiet();
    wait_done(5);

    // watchdog expiry after 20 idle RUN cycles
    q.push_back('{8'd0, 8'd0, 1'b0, 1'b1});
    start_run(6'd1, 6'd0);
    wait_run();
    repeat (19) tick();
    check("t3_done_early", done, 0);
    tick();
    check("t3_done", done, 1);
    check("t3_timeout", timeout, 1);

    // second transfer arrives after DONE: no change
    mem[0][0] = 11'sd42;
    q.push_back('{8'd1, 8'd1, 1'b1, 1'b0});
    start_run(6'd1, 6'd0);
    wait_run();
    xfer(4'b0001, 11'sd42, 0);
    xfer(4'b0001, 11'sd42, 0);
    quiet();
    check("t4_count", count, 1);
    check("t4_idx", exp_idx[0], 1);

    // true overrun while another lane keeps the run alive
    mem[1][0] = -11'sd3;
    q.push_back('{8'd2, 8'd2, 1'b0, 1'b0});
    start_run(6'd1, 6'd1);
    wait_run();
    xfer(4'b0001, 11'sd42, 0);
    xfer(4'b0001, 11'sd42, 0);
    check("t5_ovr_count", count, 1);
    check("t5_ovr_idx", exp_idx[0], 1);
    xfer(4'b0010, 0, -11'sd3);
    quiet();
    wait_done(5);

    // start ignored in RUN, then reset mid-run
    mem[0][0] = 11'sd7;
    mem[0][1] = 11'sd8;
    mem[0][2] = 11'sd9;
    start_run(6'd3, 6'd0);
    wait_run();
    xfer(4'b0001, 11'sd7, 0);
    xfer(4'b0001, 11'sd8, 0);
    quiet();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_count", count, 2);
    check("t6_idx", exp_idx[0], 2);
    tick();
    check("t6_core_rst", core_rst, 0);
    check("t6_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_core_rst", core_rst, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_correct", correct, 0);
    check("t6_rst_idx", exp_idx[0], 0);

    // all-zero lengths, then restarts from DONE
    q.push_back('{8'd0, 8'd0, 1'b1, 1'b0});
    start_run(6'd0, 6'd0);
    wait_run();
    tick();
    check("t7_done", done, 1);
    check("t7_pass", pass, 1);
    mem[0][0] = 11'sd100;
    mem[0][1] = -11'sd100;
    q.push_back('{8'd2, 8'd2, 1'b1, 1'b0});
    start_run(6'd2, 6'd0);
    check("t7_rehold", core_rst, 1);
    check("t7_done_clr", done, 0);
    wait_run();
    xfer(4'b0001, 11'sd100, 0);
    xfer(4'b0001, -11'sd100, 0);
    quiet();
    wait_done(5);
    q.push_back('{8'd0, 8'd0, 1'b1, 1'b0});
    start_run(6'd0, 6'd0);
    check("t7_clr_count", count, 0);
    check("t7_clr_correct", correct, 0);
    check("t7_clr_idx", exp_idx[0], 0);
    check("t7_clr_core_rst", core_rst, 1);
    wait_done(20);
    tick();
    tick();
    check("sb_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run sequencer and scorer for one test of the compiled core grid. Holds the core complex and stream rows in reset, releases them for a run, and watches every output-lane handshake. Each delivered value is compared against the expected stream, and the run ends on completion or on an idle watchdog. It sits between the bench's start/result signals and the `inrow` / `corecomplex` / `outrow` group, and replaces the free-running reset pulse.

## Interface
- `LANES`, 4, number of output lanes observed
- `HOLD_CYCLES`, 4, cycles `core_rst` is held high after a start (≥1)
- `TIMEOUT`, 1000, cycles without any output transfer before the run is abandoned (≥1)
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to begin a run
- `lane_len[0:LANES-1]`  in  6 each  expected value count per lane, sampled on accepted `start`
- `lane_write[0:LANES-1]`  in  1 each  core complex offers a value on a lane (`writeD`)
- `lane_read[0:LANES-1]`  in  1 each  sink accepts it (`wreadyD`); transfer = write & read
- `lane_out[0:LANES-1]`  in  11 each signed  value being transferred
- `exp_data[0:LANES-1]`  in  11 each signed  expected value at `exp_idx`, combinational from stream memory
- `exp_idx[0:LANES-1]`  out  6 each  per-lane index of the next expected value
- `core_rst`  out  1  reset to the core complex and stream rows
- `correct`  out  8  matching transfers
- `count`  out  8  in-range transfers
- `busy`, `done`, `pass`, `timeout`  out  1 each  run status

## Operation
- States: IDLE, HOLD, RUN, DONE.
- IDLE:
  - `core_rst`=1.
  - `start` → HOLD. On this transition: latch `lane_len`, clear `correct`, `count` and all `exp_idx`, load the hold counter, clear `pass` and `timeout`.
- HOLD:
  - `core_rst`=1 for exactly HOLD_CYCLES cycles, then → RUN.
  - `busy`=1.
- RUN:
  - `core_rst`=0, `busy`=1.
  - For each lane i, on a transfer with `exp_idx[i]` < latched length:
    - `count` += 1;
    - `correct` += 1 if `lane_out[i]` == `exp_data[i]` (full 11-bit signed compare);
    - `exp_idx[i]` += 1.
  - A transfer on a lane whose `exp_idx` has reached its length is an overrun: it sets the internal `ovr` flag, and `count` and `exp_idx` do not change.
  - Multiple lanes transferring in the same cycle are all scored that cycle. `count`/`correct` add the per-cycle sum (0..LANES) and saturate at 255.
  - Watchdog: clears to 0 on any cycle with ≥1 transfer (in-range or overrun), otherwise increments.
  - → DONE when every lane has `exp_idx` == length. Lanes with length 0 are complete from the start, so all-zero lengths reach DONE on the first RUN cycle.
  - → DONE with `timeout`=1 when the watchdog reaches TIMEOUT.
  - If completion and timeout occur in the same cycle, completion wins and `timeout` stays 0.
- DONE:
  - `core_rst`=1 (grid frozen); `done`=1.
  - `pass` = !`timeout` & !`ovr` & (`correct` == `count`).
  - `correct`, `count`, `exp_idx` and status outputs hold.
  - `start` → HOLD (new run).
- `start` in HOLD or RUN is ignored.
- `exp_idx` never exceeds its latched length; lengths are not re-sampled mid-run.

## Timing
- Reset values: state IDLE, `core_rst`=1, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `correct`=0, `count`=0, all `exp_idx`=0, `ovr`=0, watchdog 0.
- `rst` in any state (including mid-RUN) returns to these values on the next edge; a partial run's scores are discarded.
- `start` sampled in cycle N: `core_rst` stays 1 through cycle N+HOLD_CYCLES, and is 0 from cycle N+1+HOLD_CYCLES.
- Scoring is registered: a transfer in cycle T is reflected in `count`/`correct`/`exp_idx` at T+1. `exp_data` must be valid in the same cycle as `exp_idx`.
- `done` rises the cycle after the completing transfer or the TIMEOUT-th idle cycle. `pass` is valid the same cycle and `busy` falls the same cycle.
- The block never drives the handshake itself; it only observes `lane_write`/`lane_read`.

## Test plan
- Start, LANES=4, lengths {3,0,0,0}, lane 0 delivers 5,−7,999 matching expected → `done`@T+1 after last transfer, `count`=3, `correct`=3, `pass`=1, `core_rst` low exactly from N+5 with HOLD_CYCLES=4.
- Lengths {2,2,0,0}, lanes 0 and 1 transfer in the same two cycles, one lane-1 value wrong (−999 vs 999) → `count`=4, `correct`=3, `pass`=0, `timeout`=0.
- Length {1,0,0,0}, no transfers, TIMEOUT=20 → `done`=1 and `timeout`=1 at RUN cycle 20, `count`=0, `pass`=0.
- Length {1,0,0,0}, two matching lane-0 transfers → first is scored, second sets overrun; `count`=1, `correct`=1, `pass`=0 (if DONE was already entered, the check is that the second transfer produces no change).
- `rst` asserted mid-RUN with `count`=2 → next cycle all outputs at reset values, state IDLE. `start` during RUN ignored, counters continue unchanged.
- All lengths 0 → `done` and `pass`=1 one cycle after entering RUN. A second `start` from DONE clears counters and re-holds `core_rst`.
